// File: rtl/vga_pkg.sv
`default_nettype none
// ==========================================================================
// Module   : vga_pkg
// Purpose  : 640x480@60 VGA timing constants and sync FSM state types.
// Revision : 1.0 - initial release
// ==========================================================================
package vga_pkg;

  localparam int VGA_DIV      = 4;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  typedef enum logic [1:0] {
    HS_VIS  = 2'd0,
    HS_FP   = 2'd1,
    HS_SYNC = 2'd2,
    HS_BP   = 2'd3
  } h_state_t;

  typedef enum logic [1:0] {
    VS_VIS  = 2'd0,
    VS_FP   = 2'd1,
    VS_SYNC = 2'd2,
    VS_BP   = 2'd3
  } v_state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_enable_gen.sv
`default_nettype none
// ==========================================================================
// Module   : pixel_enable_gen
// Purpose  : Divides clk by DIV into a one-cycle pixel-rate clock enable.
// Revision : 1.0 - initial release
// ==========================================================================
module pixel_enable_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic pixel_adv,
  output logic pixel_tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_div_cnt;
  logic          r_tick;

  // pixel_adv is the edge on which the tick registers; other logic may
  // use it to update in the same cycle pixel_tick is seen high.
  assign pixel_adv  = enable && (r_div_cnt == C_LAST);
  assign pixel_tick = r_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else if (!enable) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_tick    <= pixel_adv;
      r_div_cnt <= pixel_adv ? '0 : r_div_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ==========================================================================
// Module   : vga_sync_gen
// Purpose  : VGA hsync/vsync/video_on and pixel coordinates on clock100.
// Revision : 1.0 - initial release
// ==========================================================================
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int   DIV         = VGA_DIV,
  parameter int   H_ACTIVE    = VGA_H_ACTIVE,
  parameter int   H_FP        = VGA_H_FP,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BP        = VGA_H_BP,
  parameter int   V_ACTIVE    = VGA_V_ACTIVE,
  parameter int   V_FP        = VGA_V_FP,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BP        = VGA_V_BP,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       clock100,
  input  logic       resetn,
  input  logic       enable,
  output logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] C_H_FP_START   = 10'(H_ACTIVE);
  localparam logic [9:0] C_H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] C_H_BP_START   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] C_H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] C_V_FP_START   = 10'(V_ACTIVE);
  localparam logic [9:0] C_V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] C_V_BP_START   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] C_V_LAST       = 10'(V_TOTAL - 1);

  logic       w_adv;
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic [9:0] w_x_nxt;
  logic [9:0] w_y_nxt;
  h_state_t   w_h_nxt;
  v_state_t   w_v_nxt;
  logic       w_hsync_nxt;
  logic       w_vsync_nxt;
  logic       w_video_nxt;
  logic       w_fs_nxt;

  logic [9:0] r_x;
  logic [9:0] r_y;
  h_state_t   r_h_state;
  v_state_t   r_v_state;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_video;
  logic       r_fs;

  pixel_enable_gen #(
    .DIV (DIV)
  ) u_pixel_enable (
    .clk        (clock100),
    .rst_n      (resetn),
    .enable     (enable),
    .pixel_adv  (w_adv),
    .pixel_tick (pixel_tick)
  );

  assign w_h_wrap = (r_x == C_H_LAST);
  assign w_v_wrap = (r_y == C_V_LAST);

  // State register: counters, FSMs and registered decode all move together
  // on the pixel-advance edge so every output changes with pixel_tick.
  always_ff @(posedge clock100 or negedge resetn) begin
    if (!resetn) begin
      r_x       <= '0;
      r_y       <= '0;
      r_h_state <= HS_VIS;
      r_v_state <= VS_VIS;
      r_hsync   <= ~SYNC_ACTIVE;
      r_vsync   <= ~SYNC_ACTIVE;
      r_video   <= 1'b0;
      r_fs      <= 1'b0;
    end else begin
      r_fs <= w_fs_nxt;
      if (w_adv) begin
        r_x       <= w_x_nxt;
        r_y       <= w_y_nxt;
        r_h_state <= w_h_nxt;
        r_v_state <= w_v_nxt;
        r_hsync   <= w_hsync_nxt;
        r_vsync   <= w_vsync_nxt;
        r_video   <= w_video_nxt;
      end
    end
  end

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    w_h_nxt = r_h_state;
    w_v_nxt = r_v_state;
    if (w_adv) begin
      w_x_nxt = w_h_wrap ? 10'd0 : r_x + 10'd1;
      case (r_h_state)
        HS_VIS:  if (w_x_nxt == C_H_FP_START)   w_h_nxt = HS_FP;
        HS_FP:   if (w_x_nxt == C_H_SYNC_START) w_h_nxt = HS_SYNC;
        HS_SYNC: if (w_x_nxt == C_H_BP_START)   w_h_nxt = HS_BP;
        HS_BP:   if (w_h_wrap)                  w_h_nxt = HS_VIS;
        default:                                w_h_nxt = HS_VIS;
      endcase
      if (w_h_wrap) begin
        w_y_nxt = w_v_wrap ? 10'd0 : r_y + 10'd1;
        case (r_v_state)
          VS_VIS:  if (w_y_nxt == C_V_FP_START)   w_v_nxt = VS_FP;
          VS_FP:   if (w_y_nxt == C_V_SYNC_START) w_v_nxt = VS_SYNC;
          VS_SYNC: if (w_y_nxt == C_V_BP_START)   w_v_nxt = VS_BP;
          VS_BP:   if (w_v_wrap)                  w_v_nxt = VS_VIS;
          default:                                w_v_nxt = VS_VIS;
        endcase
      end
    end
  end

  always_comb begin
    w_hsync_nxt = (w_h_nxt == HS_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    w_vsync_nxt = (w_v_nxt == VS_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    w_video_nxt = (w_h_nxt == HS_VIS) && (w_v_nxt == VS_VIS);
    w_fs_nxt    = w_adv && w_h_wrap && w_v_wrap;
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video;
  assign pixel_x     = r_x;
  assign pixel_y     = r_y;
  assign frame_start = r_fs;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ==========================================================================
// Module   : tb_vga_sync_gen
// Purpose  : Scoreboard bench: full-size timing instance plus a shrunken one.
// Revision : 1.0 - initial release
// ==========================================================================
module tb_vga_sync_gen;

  typedef struct {
    int   cyc;
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic von;
    logic fs;
  } exp_t;

  localparam int   D_DIV = 4;
  localparam int   D_HA = 640, D_HFP = 16, D_HS = 96, D_HBP = 48;
  localparam int   D_VA = 480, D_VFP = 10, D_VS = 2,  D_VBP = 33;
  localparam logic D_SA = 1'b0;

  // Shrunken frame (16 x 11 positions) so whole frames fit in a short run.
  localparam int   S_DIV = 2;
  localparam int   S_HA = 8, S_HFP = 2, S_HS = 4, S_HBP = 2;
  localparam int   S_VA = 6, S_VFP = 1, S_VS = 2, S_VBP = 2;
  localparam logic S_SA = 1'b1;
  localparam int   S_FRAME = 176;

  logic clock100 = 1'b0;
  logic resetn   = 1'b1;
  logic en_d     = 1'b0;
  logic en_s     = 1'b0;

  logic       tick_d, hs_d, vs_d, von_d, fs_d;
  logic [9:0] x_d, y_d;
  logic       tick_s, hs_s, vs_s, von_s, fs_s;
  logic [9:0] x_s, y_s;

  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  exp_t q_d[$];
  exp_t q_s[$];
  exp_t last_d, last_s;

  vga_sync_gen dut_d (
    .clock100 (clock100), .resetn (resetn), .enable (en_d),
    .pixel_tick (tick_d), .hsync (hs_d), .vsync (vs_d), .video_on (von_d),
    .pixel_x (x_d), .pixel_y (y_d), .frame_start (fs_d)
  );

  vga_sync_gen #(
    .DIV (S_DIV), .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
    .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP), .SYNC_ACTIVE (S_SA)
  ) dut_s (
    .clock100 (clock100), .resetn (resetn), .enable (en_s),
    .pixel_tick (tick_s), .hsync (hs_s), .vsync (vs_s), .video_on (von_s),
    .pixel_x (x_s), .pixel_y (y_s), .frame_start (fs_s)
  );

  always #5 clock100 = ~clock100;
  always @(posedge clock100) cyc <= cyc + 1;

  // Expected outputs after the pos-th tick since reset, by plain arithmetic.
  function automatic exp_t model(int pos, int c, int ha, int hfp, int hsw, int hbp,
                                 int va, int vfp, int vsw, int vbp, logic sa);
    exp_t e;
    int ht, vt;
    ht    = ha + hfp + hsw + hbp;
    vt    = va + vfp + vsw + vbp;
    e.cyc = c;
    e.x   = pos % ht;
    e.y   = (pos / ht) % vt;
    e.hs  = (e.x >= ha + hfp && e.x < ha + hfp + hsw) ? sa : ~sa;
    e.vs  = (e.y >= va + vfp && e.y < va + vfp + vsw) ? sa : ~sa;
    e.von = (e.x < ha) && (e.y < va);
    e.fs  = (pos > 0) && (e.x == 0) && (e.y == 0);
    return e;
  endfunction

  function automatic exp_t rst_exp(logic sa);
    exp_t e;
    e.cyc = -1; e.x = 0; e.y = 0;
    e.hs = ~sa; e.vs = ~sa; e.von = 1'b0; e.fs = 1'b0;
    return e;
  endfunction

  task automatic cmp(string nm, exp_t e, bit is_tick, logic [9:0] x, logic [9:0] y,
                     logic hs, logic vs, logic von, logic fs);
    bit ok;
    checks++;
    ok = (int'(x) == e.x) && (int'(y) == e.y) && (hs == e.hs) && (vs == e.vs) &&
         (von == e.von) && (is_tick ? (fs == e.fs && cyc == e.cyc) : (fs == 1'b0));
    if (!ok) begin
      failures++;
      $display("FAIL %s cyc=%0d got x=%0d y=%0d hs=%b vs=%b von=%b fs=%b expected cyc=%0d x=%0d y=%0d hs=%b vs=%b von=%b fs=%b",
               nm, cyc, x, y, hs, vs, von, fs, is_tick ? e.cyc : cyc, e.x, e.y,
               e.hs, e.vs, e.von, is_tick ? e.fs : 1'b0);
    end
  endtask

  task automatic chk(string nm, int got, int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, expv);
    end
  endtask

  task automatic wait_cyc(int t);
    while (cyc < t) @(negedge clock100);
  endtask

  // Monitors: pop on each tick, otherwise outputs must hold the last tick's values.
  always @(negedge clock100) begin
    if (!resetn) last_d = rst_exp(D_SA);
    else if (tick_d) begin
      if (q_d.size() == 0) begin
        checks++; failures++;
        $display("FAIL d_unexpected_tick cyc=%0d got x=%0d y=%0d expected no tick", cyc, x_d, y_d);
      end else begin
        last_d = q_d.pop_front();
        cmp("d_tick", last_d, 1'b1, x_d, y_d, hs_d, vs_d, von_d, fs_d);
      end
    end else cmp("d_hold", last_d, 1'b0, x_d, y_d, hs_d, vs_d, von_d, fs_d);
  end

  always @(negedge clock100) begin
    if (!resetn) last_s = rst_exp(S_SA);
    else if (tick_s) begin
      if (q_s.size() == 0) begin
        checks++; failures++;
        $display("FAIL s_unexpected_tick cyc=%0d got x=%0d y=%0d expected no tick", cyc, x_s, y_s);
      end else begin
        last_s = q_s.pop_front();
        cmp("s_tick", last_s, 1'b1, x_s, y_s, hs_s, vs_s, von_s, fs_s);
      end
    end else cmp("s_hold", last_s, 1'b0, x_s, y_s, hs_s, vs_s, von_s, fs_s);
  end

  initial begin
    int c0, c1, c2;
    last_d = rst_exp(D_SA);
    last_s = rst_exp(S_SA);
    #1 resetn = 1'b0;
    repeat (3) @(negedge clock100);
    #1;
    chk("rst_x_d", x_d, 0);        chk("rst_y_d", y_d, 0);
    chk("rst_hs_d", hs_d, 1);      chk("rst_vs_d", vs_d, 1);
    chk("rst_von_d", von_d, 0);    chk("rst_tick_d", tick_d, 0);
    chk("rst_fs_d", fs_d, 0);
    chk("rst_hs_s", hs_s, 0);      chk("rst_vs_s", vs_s, 0);
    chk("rst_von_s", von_s, 0);

    // Line 0 up to x = 100, then a 37-cycle enable drop.
    @(negedge clock100);
    c0 = cyc;
    for (int k = 1; k <= 100; k++)
      q_d.push_back(model(k, c0 + D_DIV * k, D_HA, D_HFP, D_HS, D_HBP, D_VA, D_VFP, D_VS, D_VBP, D_SA));
    #1 resetn = 1'b1; en_d = 1'b1;
    wait_cyc(c0 + 400);
    #1 en_d = 1'b0;
    wait_cyc(c0 + 437);
    chk("dis_hold_x_d", x_d, 100);
    chk("dis_hold_y_d", y_d, 0);
    chk("dis_tick_d", tick_d, 0);
    c1 = cyc;
    for (int k = 101; k <= 1500; k++)
      q_d.push_back(model(k, c1 + D_DIV * (k - 100), D_HA, D_HFP, D_HS, D_HBP, D_VA, D_VFP, D_VS, D_VBP, D_SA));
    #1 en_d = 1'b1;

    // Asynchronous reset between edges at (700, 1), inside the hsync pulse.
    wait_cyc(c1 + D_DIV * 1400);
    #1 resetn = 1'b0;
    #1;
    chk("arst_x_d", x_d, 0);       chk("arst_y_d", y_d, 0);
    chk("arst_hs_d", hs_d, 1);     chk("arst_vs_d", vs_d, 1);
    chk("arst_von_d", von_d, 0);   chk("arst_tick_d", tick_d, 0);
    chk("arst_fs_d", fs_d, 0);
    chk("q_d_drained_1", q_d.size(), 0);

    @(negedge clock100);
    @(negedge clock100);
    c2 = cyc;
    for (int k = 1; k <= 20; k++)
      q_d.push_back(model(k, c2 + D_DIV * k, D_HA, D_HFP, D_HS, D_HBP, D_VA, D_VFP, D_VS, D_VBP, D_SA));
    for (int k = 1; k <= 2 * S_FRAME + 5; k++)
      q_s.push_back(model(k, c2 + S_DIV * k, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, S_SA));
    #1 resetn = 1'b1; en_d = 1'b1; en_s = 1'b1;

    wait_cyc(c2 + D_DIV * 20);
    #1 en_d = 1'b0;

    // Last-pixel wrap of the small frame lands on (0, 0).
    wait_cyc(c2 + S_DIV * S_FRAME);
    chk("wrap_fs_s", fs_s, 1);     chk("wrap_x_s", x_s, 0);
    chk("wrap_y_s", y_s, 0);       chk("wrap_von_s", von_s, 1);
    chk("wrap_hs_s", hs_s, 0);     chk("wrap_vs_s", vs_s, 0);

    wait_cyc(c2 + S_DIV * (2 * S_FRAME + 5));
    #1 en_s = 1'b0;
    repeat (8) @(negedge clock100);
    chk("q_d_drained_2", q_d.size(), 0);
    chk("q_s_drained", q_s.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
